// File: rtl/nco_clk_gen_pkg.sv
// Shared constants and helpers for the NCO clock generator.
package nco_clk_gen_pkg;

  // Default phase accumulator width in bits.
  localparam int unsigned ACC_W_DEF = 16;

  // Standard 16-bit increments for a 50 MHz reference.
  localparam logic [15:0] INC_12M = 16'd15729;  // 12 MHz full-speed bit clock
  localparam logic [15:0] INC_1M5 = 16'd1966;   // 1.5 MHz low-speed bit clock

  // Rounded increment for f_out from reference f_in on an acc_w-bit accumulator:
  // round(f_out * 2^acc_w / f_in).
  function automatic logic [31:0] calc_inc(input longint unsigned f_out,
                                           input longint unsigned f_in,
                                           input int unsigned     acc_w);
    longint unsigned scaled;
    scaled = (f_out << acc_w) + (f_in >> 1);
    return 32'(scaled / f_in);
  endfunction

endpackage

// File: rtl/nco_inc_ctrl.sv
// Increment control: clamps loaded increments, holds one pending value and
// decides when it replaces the active increment.
module nco_inc_ctrl
  import nco_clk_gen_pkg::*;
#(
  parameter int unsigned ACC_W   = ACC_W_DEF,
  parameter logic [31:0] INC_RST = 32'(INC_12M)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_wrap,
  input  logic             i_phase_rst,
  input  logic [ACC_W-1:0] i_inc,
  input  logic             i_inc_load,
  output logic [ACC_W-1:0] o_inc_act,
  output logic             o_pend,
  output logic             o_clamped
);

  // Largest increment that keeps both half-periods at least one cycle long.
  localparam logic [ACC_W-1:0] INC_MAX   = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [31:0]      HALF_32   = 32'd1 << (ACC_W-1);
  localparam logic [ACC_W-1:0] INC_RST_C = (INC_RST >= HALF_32) ? INC_MAX : INC_RST[ACC_W-1:0];

  logic [ACC_W-1:0] r_inc_act;
  logic [ACC_W-1:0] r_inc_pend;
  logic             r_pend;
  logic             r_clamped;

  logic             w_oversize;
  logic [ACC_W-1:0] w_inc_capt;
  logic             w_apply;

  // Any value with the MSB set is at or above half scale.
  assign w_oversize = i_inc[ACC_W-1];
  assign w_inc_capt = w_oversize ? INC_MAX : i_inc;

  // A pending value is taken at a wrap, at a phase resync, or at once when the
  // accumulator is stalled or frozen and so would never wrap.
  assign w_apply = r_pend & (i_wrap | i_phase_rst | ~i_en | (r_inc_act == '0));

  // Capture, apply and sticky-clamp bookkeeping.
  // NOTE: clocked state uses non-blocking assignments so every register samples
  // the pre-edge values; a coincident load and apply then swap cleanly.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_inc_act  <= INC_RST_C;
      r_inc_pend <= '0;
      r_pend     <= 1'b0;
      r_clamped  <= 1'b0;
    end else begin
      if (w_apply) begin
        r_inc_act <= r_inc_pend;
      end
      if (i_inc_load) begin
        r_inc_pend <= w_inc_capt;
        r_clamped  <= r_clamped | w_oversize;
      end
      r_pend <= i_inc_load | (r_pend & ~w_apply);
    end
  end

  assign o_inc_act = r_inc_act;
  assign o_pend    = r_pend;
  assign o_clamped = r_clamped;

endmodule

// File: rtl/nco_clk_gen.sv
// Fractional clock generator: phase accumulator with registered clock output
// and single-cycle rise/fall enables aligned to the output edges.
module nco_clk_gen
  import nco_clk_gen_pkg::*;
#(
  parameter int unsigned      ACC_W      = ACC_W_DEF,
  parameter logic [31:0]      INC_RST    = 32'(INC_12M),
  parameter logic [ACC_W-1:0] PHASE_INIT = '0
) (
  input  logic             clk50,
  input  logic             rst,
  input  logic             en,
  input  logic [ACC_W-1:0] inc_i,
  input  logic             inc_load,
  input  logic             phase_rst,
  output logic             clk_out,
  output logic             tick_rise,
  output logic             tick_fall,
  output logic             inc_pending,
  output logic             inc_clamped
);

  localparam int unsigned MSB = ACC_W - 1;

  logic [ACC_W-1:0] r_acc;
  logic             r_clk_out;
  logic             r_tick_rise;
  logic             r_tick_fall;

  logic [ACC_W-1:0] w_inc_act;
  logic [ACC_W:0]   w_sum;
  logic [ACC_W-1:0] w_acc_next;
  logic             w_carry;
  logic             w_advance;
  logic             w_wrap;

  // One extra bit on the sum exposes the wrap as a carry.
  assign w_sum      = {1'b0, r_acc} + {1'b0, w_inc_act};
  assign w_carry    = w_sum[ACC_W];
  assign w_acc_next = w_sum[ACC_W-1:0];
  assign w_advance  = en & ~phase_rst;
  assign w_wrap     = w_advance & w_carry;

  nco_inc_ctrl #(
    .ACC_W   (ACC_W),
    .INC_RST (INC_RST)
  ) u_inc_ctrl (
    .i_clk       (clk50),
    .i_rst       (rst),
    .i_en        (en),
    .i_wrap      (w_wrap),
    .i_phase_rst (phase_rst),
    .i_inc       (inc_i),
    .i_inc_load  (inc_load),
    .o_inc_act   (w_inc_act),
    .o_pend      (inc_pending),
    .o_clamped   (inc_clamped)
  );

  // Accumulator advance, resync and registered edge outputs.
  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) begin
      r_acc       <= '0;
      r_clk_out   <= 1'b1;
      r_tick_rise <= 1'b0;
      r_tick_fall <= 1'b0;
    end else if (phase_rst) begin
      r_acc       <= PHASE_INIT;
      r_clk_out   <= ~PHASE_INIT[MSB];
      r_tick_rise <= 1'b0;
      r_tick_fall <= 1'b0;
    end else if (en) begin
      r_acc       <= w_acc_next;
      r_clk_out   <= ~w_acc_next[MSB];
      r_tick_rise <= w_carry;
      r_tick_fall <= ~r_acc[MSB] & w_acc_next[MSB];
    end else begin
      r_tick_rise <= 1'b0;
      r_tick_fall <= 1'b0;
    end
  end

  assign clk_out   = r_clk_out;
  assign tick_rise = r_tick_rise;
  assign tick_fall = r_tick_fall;

endmodule

// File: tb/tb_nco_clk_gen.sv
// Self-checking bench for nco_clk_gen: directed scenarios plus randomized
// traffic against a cycle model built on plain phase arithmetic.
module tb_nco_clk_gen;
  import nco_clk_gen_pkg::*;

  localparam int unsigned W      = 16;
  localparam longint      FULL   = 65536;
  localparam longint      HALF   = 32768;
  localparam logic [15:0] P_INIT = 16'h8000;

  logic        clk50     = 1'b0;
  logic        rst       = 1'b1;
  logic        en        = 1'b0;
  logic [15:0] inc_i     = '0;
  logic        inc_load  = 1'b0;
  logic        phase_rst = 1'b0;
  logic        clk_out, tick_rise, tick_fall, inc_pending, inc_clamped;

  nco_clk_gen #(
    .ACC_W      (W),
    .INC_RST    (32'(INC_12M)),
    .PHASE_INIT (P_INIT)
  ) dut (
    .clk50       (clk50),
    .rst         (rst),
    .en          (en),
    .inc_i       (inc_i),
    .inc_load    (inc_load),
    .phase_rst   (phase_rst),
    .clk_out     (clk_out),
    .tick_rise   (tick_rise),
    .tick_fall   (tick_fall),
    .inc_pending (inc_pending),
    .inc_clamped (inc_clamped)
  );

  always #10 clk50 = ~clk50;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: phase as a plain integer in [0, FULL).
  longint m_acc, m_inc, m_pend_val;
  bit     m_pend, m_clamped, m_clk, m_rise, m_fall;

  // Run statistics.
  int cyc = 0;
  int rise_cnt, last_rise, per_min, per_max, last_pulse, alt_err;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", tag, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_acc      = 0;
    m_inc      = longint'(INC_12M);
    m_pend_val = 0;
    m_pend     = 1'b0;
    m_clamped  = 1'b0;
    m_clk      = 1'b1;
    m_rise     = 1'b0;
    m_fall     = 1'b0;
  endtask

  // One clk50 edge of the model, from the inputs present at that edge.
  task automatic model_clock();
    longint total;
    bit     wrapped;
    bit     can_wrap;
    wrapped  = 1'b0;
    m_rise   = 1'b0;
    m_fall   = 1'b0;
    can_wrap = en && (m_inc != 0);
    if (phase_rst) begin
      m_acc = longint'(P_INIT);
      m_clk = (m_acc < HALF);
    end else if (en) begin
      total   = m_acc + m_inc;
      wrapped = (total >= FULL);
      m_rise  = wrapped;
      m_fall  = (m_acc < HALF) && ((total % FULL) >= HALF);
      m_acc   = total % FULL;
      m_clk   = (m_acc < HALF);
    end
    if (m_pend && (phase_rst || wrapped || !can_wrap)) begin
      m_inc  = m_pend_val;
      m_pend = 1'b0;
    end
    if (inc_load) begin
      if (longint'(inc_i) >= HALF) begin
        m_pend_val = HALF - 1;
        m_clamped  = 1'b1;
      end else begin
        m_pend_val = longint'(inc_i);
      end
      m_pend = 1'b1;
    end
  endtask

  task automatic clear_stats();
    rise_cnt  = 0;
    last_rise = 0;
    per_min   = 1000000;
    per_max   = 0;
  endtask

  // Advance one cycle, update the model, sample #1 after the edge and compare.
  task automatic tick();
    @(posedge clk50);
    if (rst) model_reset();
    else     model_clock();
    if (rst || phase_rst) last_pulse = 0;
    #1;
    cyc++;
    check("outputs", {27'd0, clk_out, tick_rise, tick_fall, inc_pending, inc_clamped},
                     {27'd0, m_clk, m_rise, m_fall, m_pend, m_clamped});
    if (tick_rise) begin
      rise_cnt++;
      if (last_rise > 0) begin
        if (cyc - last_rise < per_min) per_min = cyc - last_rise;
        if (cyc - last_rise > per_max) per_max = cyc - last_rise;
      end
      last_rise = cyc;
    end
    if ((tick_rise && last_pulse == 1) || (tick_fall && last_pulse == 2)) alt_err++;
    if (tick_rise)      last_pulse = 1;
    else if (tick_fall) last_pulse = 2;
  endtask

  task automatic wait_apply();
    for (int i = 0; i < 60 && inc_pending; i++) tick();
    check("apply_timeout", 32'(inc_pending), 32'd0);
  endtask

  task automatic first_edges(input string tag, input int n_cyc);
    int first_fall, first_rise;
    first_fall = 0;
    first_rise = 0;
    cyc = 0;
    for (int i = 0; i < n_cyc; i++) begin
      tick();
      if (tick_fall && first_fall == 0) first_fall = cyc;
      if (tick_rise && first_rise == 0) first_rise = cyc;
    end
    check({tag, "_first_fall"}, first_fall, 3);
    check({tag, "_first_rise"}, first_rise, 5);
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int     n, toggles, both, pulses, changes, sel;
    longint rem, exp_n;
    logic   prev, hold;

    // Reset state.
    model_reset();
    last_pulse = 0;
    alt_err    = 0;
    clear_stats();
    repeat (3) tick();
    check("reset_state", {27'd0, clk_out, tick_rise, tick_fall, inc_pending, inc_clamped}, 32'h10);
    check("reset_inc_act", 32'(dut.w_inc_act), 32'(INC_12M));

    // Default 12 MHz from reset release.
    rst = 1'b0;
    en  = 1'b1;
    clear_stats();
    first_edges("rel", 5);
    repeat (50000 - 5) tick();
    check("rise_cnt_12m", rise_cnt, 12000);
    check("per_min_12m", per_min, 4);
    check("per_max_12m", per_max, 5);

    // Switch to 1.5 MHz mid-period; pending until the next wrap.
    repeat (2) tick();
    inc_i    = 16'(calc_inc(1500000, 50000000, W));
    inc_load = 1'b1;
    tick();
    inc_load = 1'b0;
    check("pend_after_load", 32'(inc_pending), 32'd1);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (tick_rise) break;
      check("pend_hold", 32'(inc_pending), 32'd1);
    end
    check("apply_wrap_seen", 32'(tick_rise), 32'd1);
    check("pend_cleared", 32'(inc_pending), 32'd0);
    clear_stats();
    repeat (10000) tick();
    check("per_min_1m5", per_min, 33);
    check("per_max_1m5", per_max, 34);
    check("rise_cnt_1m5", 32'(rise_cnt == 299 || rise_cnt == 300), 32'd1);

    // Oversized increment is clamped to half scale minus one.
    inc_i    = 16'h9000;
    inc_load = 1'b1;
    tick();
    inc_load = 1'b0;
    check("clamped_flag", 32'(inc_clamped), 32'd1);
    wait_apply();
    check("inc_act_clamped", 32'(dut.w_inc_act), 32'h7FFF);
    repeat (2) tick();
    toggles = 0;
    both    = 0;
    alt_err = 0;
    prev    = clk_out;
    repeat (64) begin
      tick();
      if (clk_out != prev) toggles++;
      prev = clk_out;
      if (tick_rise && tick_fall) both++;
    end
    check("fast_toggles", 32'(toggles >= 62), 32'd1);
    check("fast_alternate", alt_err, 0);
    check("fast_no_both", both, 0);

    // Enable held low mid-phase; resume at the exact remaining count.
    inc_i    = INC_12M;
    inc_load = 1'b1;
    tick();
    inc_load = 1'b0;
    wait_apply();
    repeat ($urandom_range(1, 4)) tick();
    if (m_acc < HALF) rem = (HALF - m_acc + m_inc - 1) / m_inc;
    else              rem = (FULL - m_acc + m_inc - 1) / m_inc;
    en      = 1'b0;
    hold    = clk_out;
    pulses  = 0;
    changes = 0;
    repeat (10) begin
      tick();
      if (tick_rise || tick_fall) pulses++;
      if (clk_out != hold) changes++;
    end
    check("en_low_pulses", pulses, 0);
    check("en_low_clk", changes, 0);
    check("en_low_acc", 32'(dut.r_acc), 32'(m_acc));
    en = 1'b1;
    n  = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      n++;
      if (tick_rise || tick_fall) break;
    end
    check("en_resume_cnt", n, 32'(rem));

    // Phase resync applies a pending load and restarts from PHASE_INIT.
    inc_i    = INC_1M5;
    inc_load = 1'b1;
    tick();
    inc_load = 1'b0;
    check("pend_before_prst", 32'(inc_pending), 32'd1);
    phase_rst = 1'b1;
    tick();
    phase_rst = 1'b0;
    check("prst_clk_out", 32'(clk_out), 32'd0);
    check("prst_pulses", {30'd0, tick_rise, tick_fall}, 32'd0);
    check("prst_pend", 32'(inc_pending), 32'd0);
    check("prst_inc_act", 32'(dut.w_inc_act), 32'(INC_1M5));
    exp_n = (FULL - longint'(P_INIT) + longint'(INC_1M5) - 1) / longint'(INC_1M5);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      n++;
      if (tick_rise) break;
    end
    check("prst_rise_cnt", n, 32'(exp_n));

    // Asynchronous reset between edges, then the release sequence again.
    repeat (7) tick();
    @(negedge clk50);
    rst = 1'b1;
    #1;
    model_reset();
    check("async_rst", {27'd0, clk_out, tick_rise, tick_fall, inc_pending, inc_clamped}, 32'h10);
    repeat (2) tick();
    rst = 1'b0;
    first_edges("rerel", 40);

    // Randomized traffic against the model.
    for (int i = 0; i < 5000; i++) begin
      en       = ($urandom_range(0, 9) != 0);
      inc_load = ($urandom_range(0, 19) == 0);
      sel      = int'($urandom_range(0, 3));
      case (sel)
        0:       inc_i = 16'($urandom_range(1, 4000));
        1:       inc_i = 16'($urandom);
        2:       inc_i = 16'd0;
        default: inc_i = 16'h8000 | 16'($urandom_range(0, 255));
      endcase
      phase_rst = ($urandom_range(0, 49) == 0);
      tick();
    end
    en        = 1'b0;
    inc_load  = 1'b0;
    phase_rst = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
